transaction_control: RTL and testbench

Executes one coin transfer between Player 1 and Player 2. It answers the main controller's start_transaction / finished_transaction handshake. It reads balances and keys from the shared balance RAM, validates the request, writes the updated balances, and drives the plotting animation. On completion or rejection it reports a status code back to the main controller.

---
 rtl/transaction_control_pkg.sv | 52 +++++
 rtl/transaction_control_if.sv | 47 ++++
 rtl/transaction_control_transfer_check.sv | 46 ++++
 rtl/transaction_control.sv | 197 +++++++++++++++++++
 tb/tb_transaction_control.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/transaction_control_pkg.sv
// ---------------------------------------------------------------------------
// transaction_control_pkg
// Purpose : shared constants and types for the coin-transfer controller.
//           Holds the balance-RAM address map, the status codes reported to
//           the main controller, and the FSM state encodings. The state
//           encodings are exported so that the hex display and the testbench
//           decode state_code the same way.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package transaction_control_pkg;

    // Balance RAM address map
    localparam logic [1:0] ADDR_P1_BAL = 2'd0;
    localparam logic [1:0] ADDR_P2_BAL = 2'd1;
    localparam logic [1:0] ADDR_P1_KEY = 2'd2;
    localparam logic [1:0] ADDR_P2_KEY = 2'd3;

    // Status codes returned with finished_transaction
    typedef logic [1:0] status_t;
    localparam status_t ST_OK       = 2'b00;
    localparam status_t ST_BAD_KEY  = 2'b01;
    localparam status_t ST_NO_FUNDS = 2'b10;
    localparam status_t ST_OVERFLOW = 2'b11;

    // FSM states; the numeric value is what appears on state_code
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_KEY    = 4'd1,
        S_WAIT_KEY  = 4'd2,
        S_RD_SRC    = 4'd3,
        S_WAIT_SRC  = 4'd4,
        S_RD_DST    = 4'd5,
        S_WAIT_DST  = 4'd6,
        S_CHECK     = 4'd7,
        S_WR_SRC    = 4'd8,
        S_WR_DST    = 4'd9,
        S_ANIM      = 4'd10,
        S_WAIT_ANIM = 4'd11,
        S_DONE      = 4'd12
    } state_t;

    // Balance address of a player (0 = P1, 1 = P2)
    function automatic logic [1:0] balAddr(input logic p);
        return p ? ADDR_P2_BAL : ADDR_P1_BAL;
    endfunction

    // Key address of a player (0 = P1, 1 = P2)
    function automatic logic [1:0] keyAddr(input logic p);
        return p ? ADDR_P2_KEY : ADDR_P1_KEY;
    endfunction

endpackage

// File: rtl/transaction_control_if.sv
// ---------------------------------------------------------------------------
// transaction_control_if
// Purpose : bundles the main-controller handshake, balance-RAM port and
//           animation handshake of the transfer controller.
// Modports: dut  - the transfer controller (transaction_control)
//           host - main controller + RAM + plotter side (testbench)
// Signals : reset_others, start_transaction, player, amount, key, mem_q,
//           done_animation (host -> dut); mem_address, mem_data, mem_wren,
//           start_animation, anim_direction, finished_transaction,
//           tx_status, state_code (dut -> host)
// ---------------------------------------------------------------------------
interface transaction_control_if
    import transaction_control_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             reset_others;
    logic             start_transaction;
    logic             player;
    logic [WIDTH-1:0] amount;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] mem_q;
    logic             done_animation;

    logic [1:0]       mem_address;
    logic [WIDTH-1:0] mem_data;
    logic             mem_wren;
    logic             start_animation;
    logic             anim_direction;
    logic             finished_transaction;
    status_t          tx_status;
    logic [3:0]       state_code;

    modport dut (
        input  reset_others, start_transaction, player, amount, key, mem_q,
               done_animation,
        output mem_address, mem_data, mem_wren, start_animation,
               anim_direction, finished_transaction, tx_status, state_code
    );

    modport host (
        output reset_others, start_transaction, player, amount, key, mem_q,
               done_animation,
        input  mem_address, mem_data, mem_wren, start_animation,
               anim_direction, finished_transaction, tx_status, state_code
    );
endinterface

// File: rtl/transaction_control_transfer_check.sv
// ---------------------------------------------------------------------------
// transfer_check
// Purpose : combinational validation of a transfer and computation of the
//           two resulting balances.
// Ports   : i_key        key entered by the sender
//           i_storedKey  key read from RAM for the sender
//           i_amount     coins to move
//           i_srcBal     sender balance
//           i_dstBal     receiver balance
//           o_status     ST_OK / ST_BAD_KEY / ST_NO_FUNDS / ST_OVERFLOW
//           o_newSrc     sender balance after the transfer
//           o_newDst     receiver balance after the transfer
// ---------------------------------------------------------------------------
module transfer_check
    import transaction_control_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic [WIDTH-1:0] i_key,
    input  logic [WIDTH-1:0] i_storedKey,
    input  logic [WIDTH-1:0] i_amount,
    input  logic [WIDTH-1:0] i_srcBal,
    input  logic [WIDTH-1:0] i_dstBal,
    output status_t          o_status,
    output logic [WIDTH-1:0] o_newSrc,
    output logic [WIDTH-1:0] o_newDst
);
    logic [WIDTH:0] w_sum;

    // One extra bit on the receiver sum exposes the overflow as its MSB
    assign w_sum    = {1'b0, i_dstBal} + {1'b0, i_amount};
    assign o_newDst = w_sum[WIDTH-1:0];
    assign o_newSrc = i_srcBal - i_amount;

    // Rejection reasons are checked in priority order: key, funds, overflow
    always_comb begin
        o_status = ST_OK;
        if (i_key != i_storedKey) begin
            o_status = ST_BAD_KEY;
        end else if (i_amount > i_srcBal) begin
            o_status = ST_NO_FUNDS;
        end else if (w_sum[WIDTH]) begin
            o_status = ST_OVERFLOW;
        end
    end
endmodule

// File: rtl/transaction_control.sv
// ---------------------------------------------------------------------------
// transaction_control
// Purpose : executes one coin transfer between Player 1 and Player 2. Reads
//           the sender key and both balances from the balance RAM, validates
//           the request, writes the new balances, launches the animation and
//           reports a status code back to the main controller.
// Params  : MEM_LATENCY  RAM read latency, address to valid mem_q (1-3)
//           WIDTH        balance / amount / key width
// Ports   : clock   system clock, rising edge
//           resetn  asynchronous active-low reset
//           bus     transaction_control_if.dut (handshake, RAM, animation)
// ---------------------------------------------------------------------------
module transaction_control
    import transaction_control_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int WIDTH       = 8
)(
    input  logic                  clock,
    input  logic                  resetn,
    transaction_control_if.dut    bus
);
    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    state_t           r_state;
    logic             r_player;
    logic [WIDTH-1:0] r_amount;
    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_storedKey;
    logic [WIDTH-1:0] r_srcBal;
    logic [WIDTH-1:0] r_dstBal;
    logic [1:0]       r_waitCnt;
    logic [1:0]       r_memAddress;
    logic [WIDTH-1:0] r_memData;
    logic             r_memWren;
    logic             r_startAnim;
    logic             r_finished;
    status_t          r_txStatus;

    status_t          w_status;
    logic [WIDTH-1:0] w_newSrc;
    logic [WIDTH-1:0] w_newDst;
    logic             w_lastWait;

    transfer_check #(.WIDTH(WIDTH)) u_check (
        .i_key       (r_key),
        .i_storedKey (r_storedKey),
        .i_amount    (r_amount),
        .i_srcBal    (r_srcBal),
        .i_dstBal    (r_dstBal),
        .o_status    (w_status),
        .o_newSrc    (w_newSrc),
        .o_newDst    (w_newDst)
    );

    // Final cycle of a RAM wait, when mem_q belongs to the held address
    assign w_lastWait = (r_waitCnt == LAT_LAST);

    assign bus.mem_address          = r_memAddress;
    assign bus.mem_data             = r_memData;
    assign bus.mem_wren             = r_memWren;
    assign bus.start_animation      = r_startAnim;
    assign bus.anim_direction       = r_player;
    assign bus.finished_transaction = r_finished;
    assign bus.tx_status            = r_txStatus;
    assign bus.state_code           = r_state;

    // Transfer sequencer. Outputs are registered: each transition loads the
    // values the next state presents, so every output is glitch-free. The
    // soft clear from the main controller outranks every transition.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_player     <= 1'b0;
            r_amount     <= '0;
            r_key        <= '0;
            r_storedKey  <= '0;
            r_srcBal     <= '0;
            r_dstBal     <= '0;
            r_waitCnt    <= '0;
            r_memAddress <= '0;
            r_memData    <= '0;
            r_memWren    <= 1'b0;
            r_startAnim  <= 1'b0;
            r_finished   <= 1'b0;
            r_txStatus   <= ST_OK;
        end else if (!bus.reset_others) begin
            r_state      <= S_IDLE;
            r_player     <= 1'b0;
            r_amount     <= '0;
            r_key        <= '0;
            r_storedKey  <= '0;
            r_srcBal     <= '0;
            r_dstBal     <= '0;
            r_waitCnt    <= '0;
            r_memAddress <= '0;
            r_memData    <= '0;
            r_memWren    <= 1'b0;
            r_startAnim  <= 1'b0;
            r_finished   <= 1'b0;
            r_txStatus   <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_transaction) begin
                        r_player     <= bus.player;
                        r_amount     <= bus.amount;
                        r_key        <= bus.key;
                        r_txStatus   <= ST_OK;
                        r_memAddress <= keyAddr(bus.player);
                        r_state      <= S_RD_KEY;
                    end
                end
                S_RD_KEY: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT_KEY;
                end
                S_WAIT_KEY: begin
                    if (w_lastWait) begin
                        r_storedKey  <= bus.mem_q;
                        r_memAddress <= balAddr(r_player);
                        r_state      <= S_RD_SRC;
                    end else begin
                        r_waitCnt <= r_waitCnt + 2'd1;
                    end
                end
                S_RD_SRC: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT_SRC;
                end
                S_WAIT_SRC: begin
                    if (w_lastWait) begin
                        r_srcBal     <= bus.mem_q;
                        r_memAddress <= balAddr(~r_player);
                        r_state      <= S_RD_DST;
                    end else begin
                        r_waitCnt <= r_waitCnt + 2'd1;
                    end
                end
                S_RD_DST: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT_DST;
                end
                S_WAIT_DST: begin
                    if (w_lastWait) begin
                        r_dstBal <= bus.mem_q;
                        r_state  <= S_CHECK;
                    end else begin
                        r_waitCnt <= r_waitCnt + 2'd1;
                    end
                end
                S_CHECK: begin
                    r_txStatus <= w_status;
                    if (w_status != ST_OK) begin
                        r_finished <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_memAddress <= balAddr(r_player);
                        r_memData    <= w_newSrc;
                        r_memWren    <= 1'b1;
                        r_state      <= S_WR_SRC;
                    end
                end
                S_WR_SRC: begin
                    r_memAddress <= balAddr(~r_player);
                    r_memData    <= w_newDst;
                    r_memWren    <= 1'b1;
                    r_state      <= S_WR_DST;
                end
                S_WR_DST: begin
                    r_memWren   <= 1'b0;
                    r_startAnim <= 1'b1;
                    r_state     <= S_ANIM;
                end
                S_ANIM: begin
                    r_startAnim <= 1'b0;
                    r_state     <= S_WAIT_ANIM;
                end
                S_WAIT_ANIM: begin
                    if (bus.done_animation) begin
                        r_finished <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!bus.start_transaction) begin
                        r_finished <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_transaction_control.sv
// ---------------------------------------------------------------------------
// tb_transaction_control
// Purpose : drives two copies of the transfer controller in lockstep, one
//           with a 1-cycle RAM and one with a 3-cycle RAM. Expected RAM
//           writes, animation launches and completions are queued when a
//           request is issued and matched by a monitor as they appear.
// ---------------------------------------------------------------------------
module tb_transaction_control;
    import transaction_control_pkg::*;

    typedef enum int {EV_WRITE, EV_ANIM, EV_FIN} evKind_t;

    typedef struct {
        evKind_t    kind;
        logic [1:0] addr;
        logic [7:0] data;
        logic [1:0] status;
        int         cycle;
    } expEvent_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         edgeCount = 0;
    int         t0 = 0;
    bit         animEnable = 1'b1;
    int         animCnt1 = 0;
    int         animCnt3 = 0;
    logic       prevFin1 = 1'b0;
    logic       prevFin3 = 1'b0;
    logic [7:0] mem1 [4];
    logic [7:0] mem3 [4];
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    expEvent_t  q1 [$];
    expEvent_t  q3 [$];

    transaction_control_if #(.WIDTH(8)) if1 ();
    transaction_control_if #(.WIDTH(8)) if3 ();

    transaction_control #(.MEM_LATENCY(1), .WIDTH(8)) dut1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if1)
    );

    transaction_control #(.MEM_LATENCY(3), .WIDTH(8)) dut3 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if3)
    );

    always #5 clock = ~clock;

    // Both controllers see the same main-controller requests
    assign if3.reset_others      = if1.reset_others;
    assign if3.start_transaction = if1.start_transaction;
    assign if3.player            = if1.player;
    assign if3.amount            = if1.amount;
    assign if3.key               = if1.key;
    assign if1.mem_q             = pipe1;
    assign if3.mem_q             = pipe3[2];

    // Balance RAMs: read pipelines of depth 1 and 3, write on the edge
    always @(posedge clock) begin
        edgeCount = edgeCount + 1;
        pipe1    = mem1[if1.mem_address];
        pipe3[2] = pipe3[1];
        pipe3[1] = pipe3[0];
        pipe3[0] = mem3[if3.mem_address];
        if (if1.mem_wren) mem1[if1.mem_address] = if1.mem_data;
        if (if3.mem_wren) mem3[if3.mem_address] = if3.mem_data;
    end

    function automatic void checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    // Pops the next expected event of one instance and compares it
    task automatic checkOutput(input int inst, input evKind_t kind, input logic [1:0] addr,
                               input logic [7:0] data, input logic [1:0] status, input int cyc);
        expEvent_t e;
        bit        bad;
        checks++;
        if ((inst == 1 && q1.size() == 0) || (inst == 3 && q3.size() == 0)) begin
            errors++;
            $display("[TB] FAIL unexpected_event inst %0d: got %s at cycle %0d, expected no event",
                     inst, kind.name(), cyc);
            return;
        end
        e   = (inst == 1) ? q1.pop_front() : q3.pop_front();
        bad = (e.kind != kind) || (e.cycle >= 0 && e.cycle != cyc);
        if (kind == EV_WRITE) bad = bad || (e.addr != addr) || (e.data != data);
        if (kind == EV_FIN)   bad = bad || (e.status != status);
        if (bad) begin
            errors++;
            $display("[TB] FAIL event inst %0d: got %s addr %0d data %0d status %0d cycle %0d, expected %s addr %0d data %0d status %0d cycle %0d",
                     inst, kind.name(), addr, data, status, cyc,
                     e.kind.name(), e.addr, e.data, e.status, e.cycle);
        end
    endtask

    // Monitor and animation responders, away from the active edge
    always @(negedge clock) begin
        int cyc;
        cyc = edgeCount - t0 + 1;
        if (if1.mem_wren === 1'b1) checkOutput(1, EV_WRITE, if1.mem_address, if1.mem_data, 2'b00, cyc);
        if (if3.mem_wren === 1'b1) checkOutput(3, EV_WRITE, if3.mem_address, if3.mem_data, 2'b00, cyc);
        if (if1.start_animation === 1'b1) checkOutput(1, EV_ANIM, 2'b00, 8'd0, 2'b00, cyc);
        if (if3.start_animation === 1'b1) checkOutput(3, EV_ANIM, 2'b00, 8'd0, 2'b00, cyc);
        if (if1.finished_transaction === 1'b1 && !prevFin1) checkOutput(1, EV_FIN, 2'b00, 8'd0, if1.tx_status, cyc);
        if (if3.finished_transaction === 1'b1 && !prevFin3) checkOutput(3, EV_FIN, 2'b00, 8'd0, if3.tx_status, cyc);
        prevFin1 = (if1.finished_transaction === 1'b1);
        prevFin3 = (if3.finished_transaction === 1'b1);

        if (animCnt1 != 0) begin
            animCnt1--;
            if1.done_animation = (animCnt1 == 0);
        end else begin
            if1.done_animation = 1'b0;
        end
        if (if1.start_animation === 1'b1 && animEnable) animCnt1 = 3;
        if (animCnt3 != 0) begin
            animCnt3--;
            if3.done_animation = (animCnt3 == 0);
        end else begin
            if3.done_animation = 1'b0;
        end
        if (if3.start_animation === 1'b1 && animEnable) animCnt3 = 3;
    end

    task automatic loadMem(input logic [7:0] p1Bal, input logic [7:0] p2Bal,
                           input logic [7:0] p1Key, input logic [7:0] p2Key);
        mem1[0] = p1Bal; mem1[1] = p2Bal; mem1[2] = p1Key; mem1[3] = p2Key;
        mem3[0] = p1Bal; mem3[1] = p2Bal; mem3[2] = p1Key; mem3[3] = p2Key;
    endtask

    function automatic expEvent_t mkEvent(input evKind_t kind, input logic [1:0] addr,
                                          input logic [7:0] data, input logic [1:0] status, input int cyc);
        expEvent_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.status = status; e.cycle = cyc;
        return e;
    endfunction

    // Accepted transfer: two writes, launch in cycle 10 (16 with 3-cycle RAM),
    // completion four cycles after launch given the responder delay
    task automatic expectOk(input logic [1:0] srcAddr, input logic [7:0] srcVal,
                            input logic [1:0] dstAddr, input logic [7:0] dstVal, input bit withFin);
        q1.push_back(mkEvent(EV_WRITE, srcAddr, srcVal, 2'b00, -1));
        q1.push_back(mkEvent(EV_WRITE, dstAddr, dstVal, 2'b00, -1));
        q1.push_back(mkEvent(EV_ANIM, 2'b00, 8'd0, 2'b00, 10));
        q3.push_back(mkEvent(EV_WRITE, srcAddr, srcVal, 2'b00, -1));
        q3.push_back(mkEvent(EV_WRITE, dstAddr, dstVal, 2'b00, -1));
        q3.push_back(mkEvent(EV_ANIM, 2'b00, 8'd0, 2'b00, 16));
        if (withFin) begin
            q1.push_back(mkEvent(EV_FIN, 2'b00, 8'd0, ST_OK, 14));
            q3.push_back(mkEvent(EV_FIN, 2'b00, 8'd0, ST_OK, 20));
        end
    endtask

    // Rejected transfer: completion in cycle 8 (14 with 3-cycle RAM)
    task automatic expectReject(input logic [1:0] status);
        q1.push_back(mkEvent(EV_FIN, 2'b00, 8'd0, status, 8));
        q3.push_back(mkEvent(EV_FIN, 2'b00, 8'd0, status, 14));
    endtask

    task automatic issueRequest(input logic p, input logic [7:0] amt, input logic [7:0] k);
        @(negedge clock);
        if1.start_transaction = 1'b1;
        if1.player = p;
        if1.amount = amt;
        if1.key    = k;
        @(posedge clock);
        #1 t0 = edgeCount;
    endtask

    // One full request: hold start until both controllers finish, then release
    task automatic applyStimulus(input logic p, input logic [7:0] amt, input logic [7:0] k,
                                 input logic [1:0] expStatus);
        bit seen;
        issueRequest(p, amt, k);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (if1.finished_transaction && if3.finished_transaction) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL finish_timeout: got no finished_transaction, expected one within 100 cycles");
        end
        if1.start_transaction = 1'b0;
        if1.amount = 8'hEE;
        if1.key    = 8'hEE;
        @(negedge clock);
        checkValue("idle_after_done", int'(if1.state_code), int'(S_IDLE));
        checkValue("status_retained", int'(if1.tx_status), int'(expStatus));
        checkValue("status_retained_l3", int'(if3.tx_status), int'(expStatus));
    endtask

    task automatic waitState3(input state_t target, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (if3.state_code == target) begin
                seen = 1'b1;
                break;
            end
        end
        checkValue(name, int'(seen), 1);
    endtask

    task automatic checkCleared(input string tag);
        checkValue({tag, "_state"},    int'(if1.state_code), int'(S_IDLE));
        checkValue({tag, "_finished"}, int'(if1.finished_transaction), 0);
        checkValue({tag, "_status"},   int'(if1.tx_status), 0);
        checkValue({tag, "_wren"},     int'(if1.mem_wren), 0);
        checkValue({tag, "_anim"},     int'(if1.start_animation), 0);
        checkValue({tag, "_addr"},     int'(if1.mem_address), 0);
        checkValue({tag, "_data"},     int'(if1.mem_data), 0);
        checkValue({tag, "_dir"},      int'(if1.anim_direction), 0);
        checkValue({tag, "_state_l3"}, int'(if3.state_code), int'(S_IDLE));
    endtask

    initial begin
        if1.reset_others      = 1'b1;
        if1.start_transaction = 1'b0;
        if1.player            = 1'b0;
        if1.amount            = 8'd0;
        if1.key               = 8'd0;
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        repeat (3) @(negedge clock);
        checkCleared("reset");
        resetn = 1'b1;

        $display("[TB] basic transfer P1 -> P2");
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        expectOk(ADDR_P1_BAL, 8'd20, ADDR_P2_BAL, 8'd50, 1'b1);
        applyStimulus(1'b0, 8'd30, 8'h5A, ST_OK);
        checkValue("mem_p1_after", int'(mem1[0]), 20);
        checkValue("mem_p2_after_l3", int'(mem3[1]), 50);

        $display("[TB] rejections and boundaries");
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        expectReject(ST_BAD_KEY);
        applyStimulus(1'b0, 8'd30, 8'h5B, ST_BAD_KEY);
        loadMem(8'd10, 8'd20, 8'h5A, 8'h33);
        expectReject(ST_NO_FUNDS);
        applyStimulus(1'b0, 8'd11, 8'h5A, ST_NO_FUNDS);
        expectReject(ST_BAD_KEY);
        applyStimulus(1'b0, 8'd11, 8'h00, ST_BAD_KEY);
        expectOk(ADDR_P1_BAL, 8'd0, ADDR_P2_BAL, 8'd30, 1'b1);
        applyStimulus(1'b0, 8'd10, 8'h5A, ST_OK);
        loadMem(8'd50, 8'd250, 8'h5A, 8'h33);
        expectReject(ST_OVERFLOW);
        applyStimulus(1'b0, 8'd6, 8'h5A, ST_OVERFLOW);
        expectOk(ADDR_P1_BAL, 8'd45, ADDR_P2_BAL, 8'd255, 1'b1);
        applyStimulus(1'b0, 8'd5, 8'h5A, ST_OK);
        checkValue("mem_p2_full", int'(mem1[1]), 255);

        $display("[TB] P2 -> P1 and zero amount");
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        expectOk(ADDR_P2_BAL, 8'd13, ADDR_P1_BAL, 8'd57, 1'b1);
        applyStimulus(1'b1, 8'd7, 8'h33, ST_OK);
        expectReject(ST_BAD_KEY);
        applyStimulus(1'b1, 8'd7, 8'h5A, ST_BAD_KEY);
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        expectOk(ADDR_P1_BAL, 8'd50, ADDR_P2_BAL, 8'd20, 1'b1);
        applyStimulus(1'b0, 8'd0, 8'h5A, ST_OK);

        $display("[TB] soft clear during animation wait");
        animEnable = 1'b0;
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        expectOk(ADDR_P1_BAL, 8'd20, ADDR_P2_BAL, 8'd50, 1'b0);
        issueRequest(1'b0, 8'd30, 8'h5A);
        waitState3(S_WAIT_ANIM, "reach_wait_anim_l3");
        checkValue("held_wait_anim", int'(if1.state_code), int'(S_WAIT_ANIM));
        if1.reset_others      = 1'b0;
        if1.start_transaction = 1'b0;
        @(posedge clock);
        #1 checkCleared("soft_clear");
        @(negedge clock);
        if1.reset_others = 1'b1;
        animEnable = 1'b1;

        $display("[TB] hard reset during source read");
        loadMem(8'd50, 8'd20, 8'h5A, 8'h33);
        issueRequest(1'b1, 8'd7, 8'h33);
        for (int i = 0; i < 20 && if1.state_code != S_RD_SRC; i++) @(negedge clock);
        checkValue("rd_src_addr", int'(if1.mem_address), int'(ADDR_P2_BAL));
        checkValue("rd_src_dir", int'(if1.anim_direction), 1);
        resetn = 1'b0;
        if1.start_transaction = 1'b0;
        #1 checkCleared("hard_reset");
        @(negedge clock);
        resetn = 1'b1;
        expectOk(ADDR_P1_BAL, 8'd20, ADDR_P2_BAL, 8'd50, 1'b1);
        applyStimulus(1'b0, 8'd30, 8'h5A, ST_OK);

        repeat (4) @(negedge clock);
        checkValue("queue_empty", q1.size(), 0);
        checkValue("queue_empty_l3", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
